// File: rtl/imem_sram_bridge.sv
// Instruction-memory responder: one-entry fetch buffer in front of a
// multi-cycle external SRAM read, with stall and fault back to IF.
module imem_sram_bridge #(
  parameter logic [31:0] ADDR_BASE   = 32'h80000000,
  parameter int          SRAM_AW     = 20,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        im_addr,
  output logic [31:0]        im_data,
  output logic               im_stall,
  output logic               im_fault,
  input  logic               inv,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [31:0]        sram_data_in,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [32:0] WIN_LO = {1'b0, ADDR_BASE};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'd1 << (SRAM_AW + 2));
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

  typedef enum logic {IDLE, READ} state_t;

  state_t state_q, state_d;

  logic [31:0]        buf_addr_q, buf_addr_d;
  logic [31:0]        buf_data_q, buf_data_d;
  logic               buf_valid_q, buf_valid_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               drop_q, drop_d;
  logic [SRAM_AW-1:0] sram_addr_d;
  logic               ce_n_d, oe_n_d;

  logic in_range, aligned, hit, fault;

  assign in_range = ({1'b0, im_addr} >= WIN_LO)
                 && ({1'b0, im_addr} < WIN_HI);
  assign aligned  = (im_addr[1:0] == 2'b00);
  assign hit      = buf_valid_q && (buf_addr_q == im_addr);
  assign fault    = !(in_range && aligned);

  assign im_fault  = fault;
  assign im_data   = fault ? 32'h0000_0000 : buf_data_q;
  assign im_stall  = !fault && ((state_q == READ) || !hit);
  assign sram_we_n = 1'b1;

  always_comb begin
    state_d     = state_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    buf_valid_d = buf_valid_q;
    req_addr_d  = req_addr_q;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    sram_addr_d = sram_addr;
    ce_n_d      = sram_ce_n;
    oe_n_d      = sram_oe_n;
    unique case (state_q)
      IDLE: begin
        if (!fault && !hit) begin
          req_addr_d  = im_addr;
          sram_addr_d = im_addr[SRAM_AW+1:2];
          ce_n_d      = 1'b0;
          oe_n_d      = 1'b0;
          cnt_d       = CNT_INIT;
          drop_d      = 1'b0;
          state_d     = READ;
        end
      end
      READ: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (!drop_q) begin
            buf_data_d  = sram_data_in;
            buf_addr_d  = req_addr_q;
            buf_valid_d = 1'b1;
          end
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          state_d = IDLE;
        end
        if (inv) drop_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // invalidate beats a fill landing on the same edge
    if (inv) buf_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
      req_addr_q  <= '0;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
      sram_addr   <= '0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      state_q     <= state_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
      req_addr_q  <= req_addr_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      sram_addr   <= sram_addr_d;
      sram_ce_n   <= ce_n_d;
      sram_oe_n   <= oe_n_d;
    end
  end

endmodule

// File: doc/imem_sram_bridge.md
# imem_sram_bridge

Instruction-memory responder behind the IF stage. Takes the fetch address each cycle and returns the instruction word from the external base SRAM through a multi-cycle read. It keeps a one-entry fetch buffer so repeated fetches of the same word return immediately. It asserts a stall toward IF, feeding IF's bubble input, while a read is in flight.

## Interface
- `ADDR_BASE`, default 32'h80000000: physical base of the SRAM window.
- `SRAM_AW`, default 20: SRAM word-address width; the window is 4·2^SRAM_AW bytes.
- `WAIT_CYCLES`, default 2: SRAM read cycles per access, ≥1.
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `im_addr` in 32: fetch byte address from IF.
- `im_data` out 32: instruction word (combinational).
- `im_stall` out 1: fetch not ready; IF must hold its address (combinational).
- `im_fault` out 1: address outside the window or misaligned (combinational).
- `inv` in 1: invalidate fetch buffer (store to instruction space).
- `sram_addr` out SRAM_AW: word address (registered).
- `sram_data_in` in 32: SRAM read data.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n` out 1 each: active-low strobes (registered). `sram_we_n` is constant 1.

## Operation
- Decode, combinational:
  - `in_range` = `im_addr` ≥ ADDR_BASE and `im_addr` < ADDR_BASE + 4·2^SRAM_AW.
  - `aligned` = `im_addr[1:0]` == 0.
  - `hit` = `buf_valid` and `buf_addr` == `im_addr`.
- Fault path: when `!(in_range && aligned)`, `im_fault`=1, `im_data`=32'h00000000 (NOP), `im_stall`=0. No SRAM access starts. This covers pre-start PCs below the base.
- Hit path: `im_data`=`buf_data`, `im_stall`=0, `im_fault`=0.
- Miss in range: `im_stall`=1, `im_data`=`buf_data` (don't-care).
- Registers: `buf_addr[31:0]`, `buf_data[31:0]`, `buf_valid`, `req_addr[31:0]`, `cnt` (clog2(WAIT_CYCLES+1) bits), `drop`.
- FSM states:
  - IDLE:
    - On a miss with in_range and aligned, latch `req_addr`<=`im_addr`, `sram_addr`<=`im_addr[SRAM_AW+1:2]`, `sram_ce_n`<=0, `sram_oe_n`<=0, `cnt`<=WAIT_CYCLES-1, `drop`<=0, and go to READ.
    - Otherwise stay in IDLE.
  - READ:
    - While `cnt`≠0, `cnt`<=`cnt`-1.
    - When `cnt`==0, sample `sram_data_in`. If `drop`==0, write `buf_data`<=sample, `buf_addr`<=`req_addr`, `buf_valid`<=1. Then `sram_ce_n`/`sram_oe_n`<=1 and go to IDLE.
- Stall output: `im_stall` is 1 throughout READ regardless of hit, unless faulting.
- `inv` rules:
  - `inv` clears `buf_valid` at the edge.
  - `inv` during READ also sets `drop`<=1, so the in-flight fill is discarded.
  - `inv` on the completing cycle wins: `buf_valid` ends 0.
- Address change during READ: the read finishes for `req_addr` and fills the buffer. IDLE then re-evaluates `im_addr`; a mismatch starts a new read. An address change never aborts a read.
- Arithmetic: the range compare is 33-bit unsigned, so the window end at 2^32 cannot wrap. `sram_addr` truncates to SRAM_AW bits.

## Timing
- Reset values: state=IDLE; `buf_valid`=0, `buf_addr`=0, `buf_data`=0, `cnt`=0, `drop`=0, `req_addr`=0; `sram_addr`=0, `sram_ce_n`=1, `sram_oe_n`=1, `sram_we_n`=1.
- Reset mid-READ: the strobes deassert at that edge and the fill is lost.
- Miss latency: `im_stall` is high for exactly WAIT_CYCLES+1 cycles:
  - the detect cycle in IDLE, plus
  - WAIT_CYCLES cycles in READ;
  - data is valid, with stall low, in the first IDLE cycle after READ.
- Strobes: active for exactly WAIT_CYCLES cycles per access. `sram_addr` is stable for the whole access.
- SRAM sampling: `sram_data_in` is sampled at the rising edge that ends the last READ cycle. The SRAM must meet output-valid within WAIT_CYCLES·Tclk of `oe_n` falling.
- Hit and fault paths have zero-cycle latency.
- Back-to-back misses: at best one access per WAIT_CYCLES+1 cycles, with no idle gap beyond the detect cycle.

## Test plan
- Reset, then `im_addr`=32'h80000000 with SRAM word 0 = 32'h3C011234 (WAIT_CYCLES=2):
  - `im_stall`=1 for 3 cycles, `ce_n`/`oe_n` low for 2 cycles with `sram_addr`=0;
  - 4th cycle: `im_data`=32'h3C011234, `im_stall`=0.
- Hold 32'h80000000 after the fill: `im_stall`=0 every cycle, no further strobes. Step to 32'h80000004: new 3-cycle stall, `sram_addr`=1.
- Fault addresses:
  - `im_addr`=32'h7FFFFFFC: `im_fault`=1, `im_data`=0, `im_stall`=0, strobes idle.
  - `im_addr`=32'h80000002 (misaligned): same response.
- `inv` pulsed in the 2nd READ cycle of a fetch of 32'h80000008: the fill is discarded and `buf_valid`=0; the held address re-fetches with another 3-cycle stall.
- Change `im_addr` from 32'h80000010 to 32'h80000020 mid-READ:
  - the first read completes with `sram_addr`=4;
  - the next IDLE cycle misses and starts a read with `sram_addr`=8.
- Assert `rst` during READ: the strobes deassert at the next edge and `buf_valid`=0. After release, the same address causes a full 3-cycle miss.
